// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming KxK convolution engine.
// FSM states, derived widths and the identity-kernel coefficient.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  function automatic int acc_width(
    input int pix_w,
    input int coef_w,
    input int k
  );
    return pix_w + coef_w + $clog2(k * k) + 1;
  endfunction

  // Address/index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Identity kernel: centre tap is one, all others zero.
  function automatic int ident_coef(
    input int idx,
    input int k
  );
    return (idx == (k * k) / 2) ? 1 : 0;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: dout is the pixel written DEPTH shifts ago.
// Ports: clk, rst_n, en (shift), din (new pixel), dout (pixel one row up).
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 368,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = idx_width(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same slot gives exactly DEPTH shifts of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

  // Contents are never reset; stale rows are masked by the window logic.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution over a ROM image, one signed MAC per window.
// Ports: start/busy/done control, rom_row/rom_col/rom_data ROM port,
// coef_we/coef_idx/coef_data kernel load, out_* valid/ready result stream.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int IMG_W  = 368,
  parameter int IMG_H  = 35,
  parameter int ROM_DW = 12,
  parameter int PIX_W  = 4,
  parameter int K      = 3,
  parameter int COEF_W = 4,
  localparam int ACC_W = acc_width(PIX_W, COEF_W, K),
  localparam int RW    = idx_width(IMG_H),
  localparam int CW    = idx_width(IMG_W),
  localparam int NK    = K * K,
  localparam int IW    = idx_width(NK)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [RW-1:0]           rom_row,
  output logic [CW-1:0]           rom_col,
  input  logic [ROM_DW-1:0]       rom_data,
  input  logic                    coef_we,
  input  logic [IW-1:0]           coef_idx,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_pix,
  output logic [RW-1:0]           out_row,
  output logic [CW-1:0]           out_col
);

  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_K     = RW'(K - 1);
  localparam logic [CW-1:0] COL_K     = CW'(K - 1);
  localparam logic [RW-1:0] OROW_LAST = RW'(IMG_H - K);
  localparam logic [CW-1:0] OCOL_LAST = CW'(IMG_W - K);
  localparam logic [IW-1:0] NK_LIM    = IW'(NK);

  state_t state;

  logic adv;
  logic rd;
  logic shift;
  logic rom_vld;
  logic skid_vld;
  logic in_vld;
  logic last_xfer;
  logic rom_unused;

  logic [PIX_W-1:0] skid;
  logic [PIX_W-1:0] in_pix;

  logic [RW-1:0] pr;
  logic [CW-1:0] pc;

  logic          win_vld;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  logic [K-1:0][PIX_W-1:0]         tap;
  logic [K-1:0][K-1:0][PIX_W-1:0]  win;
  logic [NK-1:0][COEF_W-1:0]       coef;
  logic signed [ACC_W-1:0]         mac;

  // Whole pipeline advances unless a result is parked unaccepted.
  assign adv    = !out_valid || out_ready;
  assign rd     = (state == FETCH) && adv;
  assign in_vld = rom_vld || skid_vld;
  assign in_pix = skid_vld ? skid : rom_data[PIX_W-1:0];
  assign shift  = adv && in_vld;

  assign rom_unused = ^rom_data;

  assign last_xfer = out_valid && out_ready &&
                     (out_row == OROW_LAST) &&
                     (out_col == OCOL_LAST);

  // tap[j] is the pixel j rows above the incoming one.
  assign tap[0] = in_pix;

  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    line_buffer #(
      .DEPTH(IMG_W),
      .WIDTH(PIX_W)
    ) u_lb (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (shift),
      .din  (tap[j]),
      .dout (tap[j+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rom_row <= '0;
      rom_col <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            rom_row <= '0;
            rom_col <= '0;
          end
        end
        FETCH: begin
          if (adv) begin
            if (rom_col == COL_LAST) begin
              rom_col <= '0;
              if (rom_row == ROW_LAST) begin
                rom_row <= '0;
                state   <= DRAIN;
              end else begin
                rom_row <= rom_row + 1'b1;
              end
            end else begin
              rom_col <= rom_col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A word landing while stalled waits in the skid; at most one is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_vld  <= 1'b0;
      skid_vld <= 1'b0;
      skid     <= '0;
    end else begin
      rom_vld <= rd;
      if (!adv && rom_vld) begin
        skid_vld <= 1'b1;
        skid     <= rom_data[PIX_W-1:0];
      end else if (adv) begin
        skid_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef <= '0;
      for (int i = 0; i < NK; i++) begin
        coef[i] <= COEF_W'(ident_coef(i, K));
      end
    end else if (coef_we && (state == IDLE) && (coef_idx < NK_LIM)) begin
      coef[coef_idx] <= coef_data;
    end
  end

  // Column K-1 is newest; row 0 is the oldest line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (shift) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= tap[K-1-r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr      <= '0;
      pc      <= '0;
      win_vld <= 1'b0;
      win_row <= '0;
      win_col <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        pr <= '0;
        pc <= '0;
      end else if (shift) begin
        if (pc == COL_LAST) begin
          pc <= '0;
          pr <= pr + 1'b1;
        end else begin
          pc <= pc + 1'b1;
        end
      end
      if (adv) begin
        win_vld <= in_vld && (pr >= ROW_K) && (pc >= COL_K);
        win_row <= pr - ROW_K;
        win_col <= pc - COL_K;
      end
    end
  end

  always_comb begin
    mac = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        mac = mac +
              ACC_W'($signed(coef[r*K+c])) *
              $signed({{(ACC_W-PIX_W){1'b0}}, win[r][c]});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (adv) begin
      out_valid <= win_vld;
      if (win_vld) begin
        out_pix <= mac;
        out_row <= win_row;
        out_col <= win_col;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Scoreboard bench for conv2d_stream at its default 35x368, K=3 size.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_conv2d_stream;

  localparam int W  = 368;
  localparam int H  = 35;
  localparam int NR = (H - 2) * (W - 2);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               busy;
  logic               done;
  logic [5:0]         rom_row;
  logic [8:0]         rom_col;
  logic [11:0]        rom_data;
  logic               coef_we;
  logic [3:0]         coef_idx;
  logic [3:0]         coef_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [12:0] out_pix;
  logic [5:0]         out_row;
  logic [8:0]         out_col;

  conv2d_stream u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rom_row  (rom_row),
    .rom_col  (rom_col),
    .rom_data (rom_data),
    .coef_we  (coef_we),
    .coef_idx (coef_idx),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pix  (out_pix),
    .out_row  (out_row),
    .out_col  (out_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int row;
    int col;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   res_cnt  = 0;
  int   done_cnt = 0;
  int   mode     = 0;
  int   kc[9];
  int   kv[9];

  function automatic int pixf(input int r, input int c);
    case (mode)
      0:       return (r * 4 + c) & 15;
      1:       return 15;
      default: return ((r * 37) ^ (c * 11) ^ (r * c)) & 15;
    endcase
  endfunction

  function automatic int conv(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += kc[i*3+j] * pixf(r + i, c + j);
    return s;
  endfunction

  // Synchronous ROM: registered data, junk in the unused upper bits.
  always @(posedge clk)
    rom_data <= {8'hA5, 4'(pixf(int'(rom_row), int'(rom_col)))};

  always @(negedge clk)
    if (rst_n && done) done_cnt++;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_cnt++;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL extra_result row=%0d col=%0d pix=%0d required none",
                 out_row, out_col, out_pix);
      end else begin
        e = q.pop_front();
        if (int'(out_pix) != e.pix || int'(out_row) != e.row ||
            int'(out_col) != e.col) begin
          n_err++;
          $display("FAIL result pix/row/col=%0d/%0d/%0d required %0d/%0d/%0d",
                   out_pix, out_row, out_col, e.pix, e.row, e.col);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic set_ident();
    for (int i = 0; i < 9; i++) kc[i] = (i == 4) ? 1 : 0;
  endtask

  task automatic load_k();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      coef_we   = 1'b1;
      coef_idx  = 4'(i);
      coef_data = 4'(kv[i]);
      kc[i]     = kv[i];
    end
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic push_frame();
    q.delete();
    res_cnt = 0;
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++)
        q.push_back('{conv(r, c), r, c});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run(input int budget, input bit rnd, input int stall_at,
                     input int poke_at, output bit got);
    int d0 = done_cnt;
    int col0 = 0;
    got = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      coef_we = 1'b0;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc >= stall_at && cyc < stall_at + 20) out_ready = 1'b0;
      if (cyc == stall_at) col0 = int'(rom_col);
      if (cyc == stall_at + 19) begin
        chk("stall_rom_col", int'(rom_col), col0);
        chk("stall_valid", out_valid, 1);
        if (q.size() > 0) chk("stall_pix", int'(out_pix), q[0].pix);
      end
      if (cyc == poke_at) start = 1'b1;
      if (cyc == poke_at + 3) begin
        coef_we   = 1'b1;
        coef_idx  = 4'd4;
        coef_data = 4'd7;
      end
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    start     = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic end_frame(input string nm, input bit got, input int d0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_results"}, res_cnt, NR);
    chk({nm, "_queue_left"}, q.size(), 0);
    chk({nm, "_busy_after"}, busy, 0);
  endtask

  task automatic do_reset(input string nm);
    int d0 = done_cnt;
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_pix"}, int'(out_pix), 0);
    chk({nm, "_rom_row"}, int'(rom_row), 0);
    chk({nm, "_rom_col"}, int'(rom_col), 0);
    q.delete();
    set_ident();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_no_done"}, done_cnt - d0, 0);
  endtask

  initial begin
    bit got;
    int d0;
    rst_n     = 1'b0;
    start     = 1'b0;
    coef_we   = 1'b0;
    coef_idx  = '0;
    coef_data = '0;
    out_ready = 1'b1;
    set_ident();
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pix", int'(out_pix), 0);
    chk("rst_rom_row", int'(rom_row), 0);
    chk("rst_rom_col", int'(rom_col), 0);
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // All ones on a flat 15 image: 9*15 = 135; reset mid-fetch.
    kv = '{default: 1};
    load_k();
    mode = 1;
    push_frame();
    pulse_start();
    run(1500, 1'b0, -100, -10, got);
    chk("ones_no_done", got, 0);
    chk("ones_some_results", int'(res_cnt > 100), 1);
    do_reset("rst_a");

    // All -8 on a flat 15 image: -1080, widest negative sum.
    kv = '{default: -8};
    load_k();
    push_frame();
    pulse_start();
    run(1500, 1'b0, -100, -10, got);
    chk("neg_no_done", got, 0);
    chk("neg_some_results", int'(res_cnt > 100), 1);
    do_reset("rst_b");

    // Kernel back to identity after reset: centre pixel of ramp,
    // with a 20-cycle stall and ignored start/coef_we while busy.
    mode = 0;
    push_frame();
    d0 = done_cnt;
    pulse_start();
    run(14000, 1'b0, 3000, 1000, got);
    end_frame("ident", got, d0);

    // Mixed-sign kernel, hashed image, random backpressure.
    kv = '{1, -2, 3, 0, 4, -1, 2, -3, 1};
    load_k();
    @(posedge clk); #1;
    coef_we   = 1'b1;
    coef_idx  = 4'd12;
    coef_data = 4'd5;
    @(posedge clk); #1;
    coef_we = 1'b0;
    mode = 2;
    push_frame();
    d0 = done_cnt;
    pulse_start();
    run(45000, 1'b1, -100, -10, got);
    end_frame("rand", got, d0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
